// File: rtl/spi_shift_engine_pkg.sv
// Types and helpers shared by the SPI shift engine and its clock generator.
// Pure declarations: no logic, no latency, no flow control.
`include "common.vh"

package spi_shift_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = `SPI_ST_IDLE,
        ST_ACTIVE = `SPI_ST_ACTIVE,
        ST_DONE   = `SPI_ST_DONE
    } state_t;

    localparam logic SHIFT_LEFT  = `SHIFT_DIR_LEFT;
    localparam logic SHIFT_RIGHT = `SHIFT_DIR_RIGHT;

    // Minimum counter width for the range 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/common.vh
// Shared encodings: bit-order selector and FSM state codes for the SPI shift engine.
`ifndef SPI_COMMON_VH
`define SPI_COMMON_VH

`define SHIFT_DIR_LEFT  1'b0
`define SHIFT_DIR_RIGHT 1'b1

`define SPI_ST_IDLE   2'd0
`define SPI_ST_ACTIVE 2'd1
`define SPI_ST_DONE   2'd2

`endif

// File: rtl/spi_clk_gen.sv
// Half-bit timing: DIV-cycle divider and 0..2W-1 half index, strobing the last cycle of each half.
// Combinational strobes off registered counters; counters idle at 0 whenever run is low.
module spi_clk_gen
    import spi_shift_engine_pkg::*;
#(
    parameter int W   = 8,
    parameter int DIV = 4,
    localparam int DW = cnt_width(DIV),
    localparam int HW = cnt_width(2 * W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [HW-1:0] half,
    output logic          half_end,
    output logic          last_half
);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * W - 1);

    logic [DW-1:0] div_cnt;

    assign half_end  = run && (div_cnt == DIV_LAST);
    assign last_half = (half == HALF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            half    <= '0;
        end else if (!run) begin
            div_cnt <= '0;
            half    <= '0;
        end else if (half_end) begin
            div_cnt <= '0;
            half    <= last_half ? '0 : half + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one W-bit full-duplex transfer per accept, rx_valid 2*W*DIV+1 cycles later.
// tx side is valid/ready (ready only in IDLE); rx side has no backpressure, rx_data holds until next word.
`include "common.vh"

module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int   W         = 8,
    parameter int   DIV       = 4,
    parameter logic SHIFT_DIR = `SHIFT_DIR_LEFT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic [W-1:0] tx_data,
    input  logic         cpol,
    input  logic         cpha,
    output logic         sck,
    output logic         mosi,
    input  logic         miso,
    output logic         rx_valid,
    output logic [W-1:0] rx_data,
    output logic         busy
);

    localparam int HW = cnt_width(2 * W);

    state_t        state, state_nxt;
    logic          cpol_r, cpha_r;
    logic [W-1:0]  tx_sr, rx_sr;
    logic [HW-1:0] half;
    logic          half_end, last_half;
    logic          run, accept, finish;

    assign run    = (state == ST_ACTIVE);
    assign accept = (state == ST_IDLE) && tx_valid;
    assign finish = half_end && last_half;

    spi_clk_gen #(.W(W), .DIV(DIV)) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .half      (half),
        .half_end  (half_end),
        .last_half (last_half)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_ready  = 1'b0;
        busy      = 1'b0;
        rx_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                busy = 1'b1;
                if (finish) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                rx_valid  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Odd halves end a bit: advance tx, except after the final bit.
    // Even halves end at the sampling edge: capture miso.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_r  <= 1'b0;
            cpha_r  <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
        end else begin
            if (state == ST_IDLE) cpol_r <= cpol;
            if (accept) begin
                cpha_r <= cpha;
                tx_sr  <= tx_data;
            end else if (half_end && half[0] && !last_half) begin
                tx_sr <= (SHIFT_DIR == SHIFT_LEFT) ? {tx_sr[W-2:0], 1'b0} : {1'b0, tx_sr[W-1:1]};
            end
            if (half_end && !half[0])
                rx_sr <= (SHIFT_DIR == SHIFT_LEFT) ? {rx_sr[W-2:0], miso} : {miso, rx_sr[W-1:1]};
            if (run && finish) rx_data <= rx_sr;
        end
    end

    assign sck  = run ? (cpol_r ^ cpha_r ^ half[0]) : cpol_r;
    assign mosi = run ? ((SHIFT_DIR == SHIFT_LEFT) ? tx_sr[W-1] : tx_sr[0]) : 1'b0;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: A is W=8/DIV=2 MSB-first, B is W=4/DIV=1 LSB-first.
// Expected waveforms come from the bit-timing rules evaluated per cycle.
module tb_spi_shift_engine;
    import spi_shift_engine_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // shared stimulus, routed to the selected instance
    logic       sel = 1'b0;
    logic       tv = 1'b0;
    logic [7:0] td = 8'h00;
    logic       cp = 1'b0;
    logic       ch = 1'b0;
    logic       lp = 1'b0;
    logic       miso_drv = 1'b0;

    logic       tx_ready_a, sck_a, mosi_a, rx_valid_a, busy_a, miso_a;
    logic [7:0] rx_data_a;
    logic       tx_ready_b, sck_b, mosi_b, rx_valid_b, busy_b, miso_b;
    logic [3:0] rx_data_b;

    assign miso_a = lp ? mosi_a : miso_drv;
    assign miso_b = lp ? mosi_b : miso_drv;

    spi_shift_engine #(.W(8), .DIV(2), .SHIFT_DIR(SHIFT_LEFT)) u_a (
        .clk(clk), .rst(rst), .tx_valid(tv && !sel), .tx_ready(tx_ready_a), .tx_data(td),
        .cpol(cp), .cpha(ch), .sck(sck_a), .mosi(mosi_a), .miso(miso_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a)
    );

    spi_shift_engine #(.W(4), .DIV(1), .SHIFT_DIR(SHIFT_RIGHT)) u_b (
        .clk(clk), .rst(rst), .tx_valid(tv && sel), .tx_ready(tx_ready_b), .tx_data(td[3:0]),
        .cpol(cp), .cpha(ch), .sck(sck_b), .mosi(mosi_b), .miso(miso_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b)
    );

    logic       o_ready, o_sck, o_mosi, o_rxv, o_busy;
    logic [7:0] o_rx;
    assign o_ready = sel ? tx_ready_b : tx_ready_a;
    assign o_sck   = sel ? sck_b      : sck_a;
    assign o_mosi  = sel ? mosi_b     : mosi_a;
    assign o_rxv   = sel ? rx_valid_b : rx_valid_a;
    assign o_busy  = sel ? busy_b     : busy_a;
    assign o_rx    = sel ? {4'h0, rx_data_b} : rx_data_a;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (o_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_wait", o_ready, 1);
    endtask

    // One transfer on instance s. Without hold, an idle cycle first lets sck settle to pol.
    // With hold, tx_valid stays high and tx_data switches to nxt right after accept.
    task automatic xfer(input logic s, input logic [7:0] d, input logic pol, input logic pha,
                        input logic loop, input logic [7:0] pat, input logic hold,
                        input logic [7:0] nxt);
        int w, dv, h, k, edges;
        logic prev;
        logic [7:0] exp_rx;
        w  = s ? 4 : 8;
        dv = s ? 1 : 2;
        sel = s;
        lp  = loop;
        edges = 0;
        if (!tv) begin
            cp = pol;
            @(negedge clk);
            wait_ready();
            @(negedge clk);
            chk("sck_idle", o_sck, pol);
        end else begin
            wait_ready();
        end
        tv = 1'b1; td = d; cp = pol; ch = pha;
        prev = o_sck;
        @(negedge clk);
        for (int c = 0; c < 2 * w * dv; c++) begin
            if (c == 0) begin
                if (hold) td = nxt;
                else      tv = 1'b0;
            end
            h = c / dv;
            k = h / 2;
            chk("ctl_active", {o_busy, o_ready, o_rxv}, 3'b100);
            chk("sck_half", o_sck, pol ^ pha ^ h[0]);
            chk("mosi_bit", o_mosi, s ? d[k] : d[w-1-k]);
            miso_drv = s ? pat[k] : pat[w-1-k];
            if (o_sck !== prev) edges++;
            prev = o_sck;
            cp = 1'($urandom);
            ch = 1'($urandom);
            if (!hold) td = 8'($urandom);
            @(negedge clk);
        end
        cp = pol;
        if (o_sck !== prev) edges++;
        exp_rx = loop ? d : pat;
        if (s) exp_rx = exp_rx & 8'h0F;
        chk("ctl_done", {o_busy, o_ready, o_rxv}, 3'b001);
        chk("rx_data", o_rx, exp_rx);
        chk("sck_done", o_sck, pol);
        chk("mosi_done", o_mosi, 0);
        chk("sck_edges", edges, 2 * w);
        @(negedge clk);
        chk("ctl_idle_after", {o_ready, o_rxv, o_busy}, 3'b100);
        chk("rx_data_hold", o_rx, exp_rx);
    endtask

    initial begin
        int pulses;
        logic [7:0] r;

        // reset state of both instances
        rst = 1'b1;
        cp  = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_ctl", {o_ready, o_busy, o_rxv}, 3'b100);
            chk("rst_sck", o_sck, 0);
            chk("rst_mosi", o_mosi, 0);
            chk("rst_rx", o_rx, 0);
        end
        cp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;

        // first accept right after reset release
        tv = 1'b1; td = 8'hA5; cp = 1'b0; ch = 1'b0; lp = 1'b1;
        xfer(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);

        // mode 3, slave pattern 0x3C, MSB first
        xfer(1'b0, 8'h96, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00);

        // LSB-first single set bit, mode 0
        xfer(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h09, 1'b0, 8'h00);

        // DIV=1, mode 1 loopback
        r = 8'($urandom);
        xfer(1'b1, r, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);

        // tx_valid held, tx_data changed during ACTIVE: back-to-back
        r = 8'($urandom);
        xfer(1'b0, r, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5A);
        xfer(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);

        // reset pulse at cycle 10 of a transfer
        sel = 1'b0; lp = 1'b1; cp = 1'b0; ch = 1'b0;
        wait_ready();
        tv = 1'b1; td = 8'($urandom);
        @(negedge clk);
        tv = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", o_busy, 1);
        rst = 1'b1;
        cp  = 1'b1;
        #1;
        chk("abort_ctl", {o_ready, o_busy, o_rxv}, 3'b100);
        chk("abort_sck", o_sck, 0);
        chk("abort_mosi", o_mosi, 0);
        chk("abort_rx", o_rx, 0);
        @(negedge clk);
        chk("abort_hold_ctl", {o_ready, o_busy, o_rxv, o_sck, o_mosi}, 5'b10000);
        rst = 1'b0;
        cp  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_rxv === 1'b1) pulses++;
        end
        chk("abort_no_rxv", pulses, 0);
        xfer(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);

        // randomized transfers on both instances
        for (int i = 0; i < 12; i++) begin
            xfer(1'(i % 2), 8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom), 1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter W, default 8: transfer width in bits; legal range W >= 2.
REQ-002 SHALL have parameter DIV, default 4: half-bit period in clk cycles; legal range DIV >= 1.
REQ-003 SHALL have parameter SHIFT_DIR, default `SHIFT_DIR_LEFT: bit order; LEFT sends MSB first, `SHIFT_DIR_RIGHT sends LSB first.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; the ports are clk and rst.
REQ-005 clk  input  1  system clock; all state is updated on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tx_valid  input  1  transfer request.
REQ-008 tx_ready  output  1  engine can accept a transfer.
REQ-009 tx_data  input  W  word to transmit.
REQ-010 cpol  input  1  SPI clock polarity.
REQ-011 cpha  input  1  SPI clock phase.
REQ-012 sck  output  1  SPI serial clock.
REQ-013 mosi  output  1  serial data out.
REQ-014 miso  input  1  serial data in.
REQ-015 rx_valid  output  1  one-cycle pulse: received word is valid.
REQ-016 rx_data  output  W  last received word.
REQ-017 busy  output  1  transfer in progress.

Function
REQ-018 SHALL implement the FSM states IDLE, ACTIVE and DONE, with these transitions:
- IDLE -> ACTIVE on tx_valid && tx_ready;
- ACTIVE -> DONE after the last half-bit ends;
- DONE -> IDLE unconditionally after one cycle.
REQ-019 SHALL drive tx_ready = 1 only in IDLE; busy = 1 only in ACTIVE; rx_valid = 1 only in DONE.
REQ-020 On accept (cycle 0), SHALL latch tx_data into the tx shift register and latch cpol and cpha; the latched mode is held until the next accept.
REQ-021 While in IDLE, the cpol register SHALL track the cpol input; sck SHALL equal the registered cpol in IDLE and DONE.
REQ-022 ACTIVE SHALL consist of 2*W half-bits h = 0..2W-1, each exactly DIV cycles long, so ACTIVE spans cycles 1..2*W*DIV.
REQ-023 The divider counter (0..DIV-1) and half-bit counter (0..2W-1) SHALL each be sized to the minimum width for their range and SHALL wrap to 0 at the final value.
REQ-024 During half h, sck SHALL equal cpol ^ h[0] when cpha = 0, and cpol ^ ~h[0] when cpha = 1.
REQ-025 Data bit k SHALL drive mosi during halves 2k and 2k+1.
REQ-026 The tx shift register SHALL shift at the end of each odd half except the last one.
REQ-027 miso SHALL be sampled into the rx shift register at the last cycle of each even half; this point corresponds to the sampling edge in both phase modes.
REQ-028 With SHIFT_DIR LEFT, the tx register SHALL output its MSB and rx bits SHALL shift in at the LSB; with SHIFT_DIR RIGHT, the tx register SHALL output its LSB and rx bits SHALL shift in at the MSB.
REQ-029 rx_data SHALL update to the completed word on entry to DONE (cycle 2*W*DIV+1) and SHALL hold until the next DONE.
REQ-030 mosi SHALL be 0 in IDLE and DONE.
REQ-031 tx_valid SHALL be ignored while the FSM is not in IDLE; tx_data, cpol and cpha changes during ACTIVE SHALL have no effect.
REQ-032 The earliest next accept SHALL be cycle 2*W*DIV+2.
REQ-033 tx_valid held high continuously SHALL give back-to-back transfers with one IDLE cycle between them.
REQ-034 There SHALL be no rx backpressure: an rx_valid pulse the consumer misses SHALL be lost, and rx_data SHALL remain readable until the next DONE.

Reset
REQ-035 While rst = 1, the block SHALL hold: state = IDLE, tx_ready = 1, busy = 0, rx_valid = 0, sck = 0, mosi = 0, rx_data = 0, all counters and shift registers = 0, and latched cpol/cpha = 0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer immediately; no rx_valid pulse SHALL occur for the aborted word.
REQ-037 The first accept after reset is released SHALL be legal in the first cycle in which tx_ready = 1.

Structure
REQ-038 The SHIFT_DIR constants and the FSM state encodings SHALL be defined in the shared header common.vh.
REQ-039 Sub-module spi_clk_gen SHALL contain the divider counter and half-bit counter; it SHALL output the half index, an end-of-half strobe, and a last-half flag.
REQ-040 All flops SHALL use asynchronous reset on rst.

Verification
REQ-041 Mode 0 loopback, W=8, DIV=2, miso tied to mosi, tx_data = 0xA5, accept at cycle 0 -> busy in cycles 1..32; rx_valid pulse in cycle 33 with rx_data = 0xA5; tx_ready = 1 in cycle 34.
REQ-042 Mode 3 (cpol=1, cpha=1), bench drives miso with 0x3C MSB first on sck leading edges -> rx_data = 0x3C; sck idles at 1; exactly 16 sck edges.
REQ-043 SHIFT_DIR RIGHT, tx_data = 0x01, mode 0 -> mosi = 1 during halves 0-1 only, 0 for all other halves.
REQ-044 rst pulsed at cycle 10 of a transfer -> sck = 0, mosi = 0, busy = 0, tx_ready = 1 while rst is high; no rx_valid pulse; the next transfer completes correctly.
REQ-045 tx_valid held high with tx_data changed to 0x5A during ACTIVE -> first word unaffected; second accept at cycle 34 transmits 0x5A.
REQ-046 DIV=1, W=4, mode 1 -> ACTIVE lasts exactly 8 cycles; sck toggles every cycle; loopback returns the transmitted word.
